// File: rtl/lsu.sv
// Load/store unit: one in-flight data-memory access with lane shifting, load extension and a wait timeout.
// Latency: accept -> WAIT_GNT -> WAIT_RVALID -> registered lsu_valid_op; at least 3 cycles after acceptance.
// Backpressure: requests arriving while lsu_busy_op=1 are dropped; a withheld gnt/rvalid ends in lsu_err_op after TIMEOUT_CYCLES.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (reject misaligned half/word accesses instead of aligning them).
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req_ip,
  input  logic        lsu_we_ip,
  input  logic [1:0]  lsu_size_ip,
  input  logic        lsu_unsigned_ip,
  input  logic [31:0] alu_result_ip,
  input  logic        alu_valid_ip,
  input  logic [31:0] lsu_wdata_ip,
  output logic        data_req_op,
  output logic        data_we_op,
  output logic [31:0] data_addr_op,
  output logic [3:0]  data_be_op,
  output logic [31:0] data_wdata_op,
  input  logic        data_gnt_ip,
  input  logic        data_rvalid_ip,
  input  logic [31:0] data_rdata_ip,
  output logic [31:0] lsu_rdata_op,
  output logic        lsu_valid_op,
  output logic        lsu_busy_op,
  output logic        lsu_err_op
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  // Counter value seen during the last permitted cycle of a wait state.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_uns;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_valid;
  logic        r_err;

  logic        w_accept;
  logic        w_done;
  logic        w_fail;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        w_misalign;
`endif

  // Request decode: aligned lane offset, byte enables and replicated store data.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = lsu_wdata_ip;
    case (lsu_size_ip)
      2'b00: begin
        w_off   = alu_result_ip[1:0];
        w_be    = 4'b0001 << alu_result_ip[1:0];
        w_wdata = {4{lsu_wdata_ip[7:0]}};
      end
      2'b01: begin
        w_off   = {alu_result_ip[1], 1'b0};
        w_be    = 4'b0011 << {alu_result_ip[1], 1'b0};
        w_wdata = {2{lsu_wdata_ip[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_ip;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // Half needs addr[0]=0, word (size 10/11) needs addr[1:0]=0.
  assign w_misalign = ((lsu_size_ip == 2'b01) && alu_result_ip[0]) ||
                      (lsu_size_ip[1] && (alu_result_ip[1:0] != 2'b00));
`endif

  // Next-state logic with accept/complete/error strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_fail   = 1'b0;
    case (r_state)
      IDLE: begin
        if (lsu_req_ip && alu_valid_ip) begin
`ifdef LSU_MISALIGN_CHECK_EN
          if (w_misalign) begin
            w_fail = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = WAIT_GNT;
          end
`else
          w_accept = 1'b1;
          w_next   = WAIT_GNT;
`endif
        end
      end
      WAIT_GNT: begin
        if (data_gnt_ip) begin
          w_next = WAIT_RVALID;
        end else if (r_cnt == CNT_LAST) begin
          w_fail = 1'b1;
          w_next = IDLE;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_ip) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_fail = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Load lane extraction: shift selected lane to bit 0, then sign/zero extend.
  assign w_shift = data_rdata_ip >> {r_off, 3'b000};
  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      default: w_load = data_rdata_ip;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Wait counter: cleared on every state change, counts while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_cnt <= 8'd0;
    else if (w_next != r_state)  r_cnt <= 8'd0;
    else if (r_state != IDLE)    r_cnt <= r_cnt + 8'd1;
  end

  // Access capture, result register and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_off   <= 2'd0;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_rdata <= 32'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_err   <= w_fail;
      if (w_accept) begin
        r_addr  <= {alu_result_ip[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_size  <= lsu_size_ip;
        r_off   <= w_off;
        r_uns   <= lsu_unsigned_ip;
        r_we    <= lsu_we_ip;
      end
      if (w_done) begin
        r_rdata <= r_we ? 32'd0 : w_load;
      end
    end
  end

  assign data_req_op   = (r_state == WAIT_GNT);
  assign data_we_op    = r_we;
  assign data_addr_op  = r_addr;
  assign data_be_op    = r_be;
  assign data_wdata_op = r_wdata;
  assign lsu_rdata_op  = r_rdata;
  assign lsu_valid_op  = r_valid;
  assign lsu_busy_op   = (r_state != IDLE);
  assign lsu_err_op    = r_err;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a completion scoreboard.
// Expected results are queued at issue time and popped when lsu_valid_op/lsu_err_op pulse.
// All sampling and driving happens on the falling clock edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_ip, lsu_we_ip, lsu_unsigned_ip, alu_valid_ip;
  logic [1:0]  lsu_size_ip;
  logic [31:0] alu_result_ip, lsu_wdata_ip;
  logic        data_req_op, data_we_op;
  logic [31:0] data_addr_op, data_wdata_op;
  logic [3:0]  data_be_op;
  logic        data_gnt_ip, data_rvalid_ip;
  logic [31:0] data_rdata_ip;
  logic [31:0] lsu_rdata_op;
  logic        lsu_valid_op, lsu_busy_op, lsu_err_op;

  lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .lsu_req_ip(lsu_req_ip), .lsu_we_ip(lsu_we_ip), .lsu_size_ip(lsu_size_ip),
    .lsu_unsigned_ip(lsu_unsigned_ip), .alu_result_ip(alu_result_ip),
    .alu_valid_ip(alu_valid_ip), .lsu_wdata_ip(lsu_wdata_ip),
    .data_req_op(data_req_op), .data_we_op(data_we_op), .data_addr_op(data_addr_op),
    .data_be_op(data_be_op), .data_wdata_op(data_wdata_op),
    .data_gnt_ip(data_gnt_ip), .data_rvalid_ip(data_rvalid_ip), .data_rdata_ip(data_rdata_ip),
    .lsu_rdata_op(lsu_rdata_op), .lsu_valid_op(lsu_valid_op),
    .lsu_busy_op(lsu_busy_op), .lsu_err_op(lsu_err_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    lsu_req_ip      = 1'b1;
    alu_valid_ip    = 1'b1;
    lsu_we_ip       = we;
    lsu_size_ip     = size;
    lsu_unsigned_ip = uns;
    alu_result_ip   = addr;
    lsu_wdata_ip    = wdata;
    @(negedge clk);
    lsu_req_ip   = 1'b0;
    alu_valid_ip = 1'b0;
  endtask

  task automatic push_exp(input logic err, input logic [31:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
    last_rdata = rdata;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic we, input logic [31:0] wdata);
    for (int i = 0; i < 20; i++) begin
      if (data_req_op) break;
      @(negedge clk);
    end
    chk({tag, " req"},   {31'd0, data_req_op}, 32'd1);
    chk({tag, " addr"},  data_addr_op, addr);
    chk({tag, " be"},    {28'd0, data_be_op}, {28'd0, be});
    chk({tag, " we"},    {31'd0, data_we_op}, {31'd0, we});
    if (we) chk({tag, " wdata"}, data_wdata_op, wdata);
  endtask

  // Grant after 'delay' extra cycles; returns in WAIT_RVALID.
  task automatic grant(input int delay);
    repeat (delay) @(negedge clk);
    data_gnt_ip = 1'b1;
    @(negedge clk);
    data_gnt_ip = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = rdata;
    @(negedge clk);
    data_rvalid_ip = 1'b0;
    data_rdata_ip  = 32'd0;
  endtask

  // Wait (bounded) for a completion/error pulse, compare with the scoreboard, check pulse width.
  task automatic wait_done(input string tag);
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (lsu_valid_op || lsu_err_op) break;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " valid"}, {31'd0, lsu_valid_op}, {31'd0, ~e.err});
      chk({tag, " err"},   {31'd0, lsu_err_op},   {31'd0, e.err});
      chk({tag, " rdata"}, lsu_rdata_op, e.rdata);
      chk({tag, " busy"},  {31'd0, lsu_busy_op}, 32'd0);
    end
    @(negedge clk);
    chk({tag, " pulse width"}, {30'd0, lsu_valid_op, lsu_err_op}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic seen;
    reset = 1'b1;
    lsu_req_ip = 1'b0; lsu_we_ip = 1'b0; lsu_size_ip = 2'b00; lsu_unsigned_ip = 1'b0;
    alu_result_ip = 32'd0; alu_valid_ip = 1'b0; lsu_wdata_ip = 32'd0;
    data_gnt_ip = 1'b0; data_rvalid_ip = 1'b0; data_rdata_ip = 32'd0;
    #2;
    chk("reset req/we/busy/valid/err",
        {27'd0, data_req_op, data_we_op, lsu_busy_op, lsu_valid_op, lsu_err_op}, 32'd0);
    chk("reset addr",  data_addr_op, 32'd0);
    chk("reset rdata", lsu_rdata_op, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Word load at 0x100, grant after one cycle.
    push_exp(1'b0, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    expect_req("wload", 32'h100, 4'b1111, 1'b0, 32'd0);
    grant(1);
    respond(32'hDEADBEEF);
    wait_done("wload");

    // Byte load at 0x103, signed then unsigned.
    push_exp(1'b0, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    expect_req("bload_s", 32'h100, 4'b1000, 1'b0, 32'd0);
    grant(0);
    respond(32'h80FF_0000);
    wait_done("bload_s");

    push_exp(1'b0, 32'h00000080);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
    expect_req("bload_u", 32'h100, 4'b1000, 1'b0, 32'd0);
    grant(0);
    respond(32'h80FF_0000);
    wait_done("bload_u");

    // Half store 0x1234 at 0x202 (upper input bits must not leak).
    push_exp(1'b0, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'hABCD_1234);
    expect_req("hstore", 32'h200, 4'b1100, 1'b1, 32'h12341234);
    grant(2);
    respond(32'h5555_5555);
    wait_done("hstore");

    // Byte store 0xAB at 0x001.
    push_exp(1'b0, 32'd0);
    issue(1'b1, 2'b00, 1'b0, 32'h001, 32'h1234_56AB);
    expect_req("bstore", 32'h000, 4'b0010, 1'b1, 32'hABABABAB);
    grant(0);
    respond(32'd0);
    wait_done("bstore");

    // Half loads: signed upper half, unsigned lower half.
    push_exp(1'b0, 32'hFFFF8001);
    issue(1'b0, 2'b01, 1'b0, 32'h002, 32'd0);
    expect_req("hload_s", 32'h000, 4'b1100, 1'b0, 32'd0);
    grant(0);
    respond(32'h8001_1234);
    wait_done("hload_s");

    push_exp(1'b0, 32'h00001234);
    issue(1'b0, 2'b01, 1'b1, 32'h000, 32'd0);
    expect_req("hload_u", 32'h000, 4'b0011, 1'b0, 32'd0);
    grant(0);
    respond(32'h8001_1234);
    wait_done("hload_u");

    repeat (3) @(negedge clk);
    chk("rdata hold", lsu_rdata_op, 32'h00001234);

    // Grant withheld: 16 cycles of data_req, then error; rvalid meanwhile is ignored.
    push_exp(1'b1, last_rdata);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
    cnt = 0;
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      if (!data_req_op) break;
      cnt++;
      @(negedge clk);
    end
    data_rvalid_ip = 1'b0;
    data_rdata_ip  = 32'd0;
    chk("gnt timeout req cycles", cnt, 32'd16);
    wait_done("gnt timeout");

    // Response withheld after grant: 16 cycles in WAIT_RVALID, then error.
    push_exp(1'b1, last_rdata);
    issue(1'b0, 2'b10, 1'b0, 32'h304, 32'd0);
    expect_req("rv timeout", 32'h304, 4'b1111, 1'b0, 32'd0);
    grant(0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(lsu_busy_op && !data_req_op)) break;
      cnt++;
      @(negedge clk);
    end
    chk("rvalid timeout wait cycles", cnt, 32'd16);
    wait_done("rv timeout");

    // Requests while busy are dropped; no second access follows the first.
    push_exp(1'b0, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    expect_req("busy", 32'h400, 4'b1111, 1'b0, 32'd0);
    lsu_req_ip = 1'b1; alu_valid_ip = 1'b1; lsu_we_ip = 1'b1; alu_result_ip = 32'h500;
    @(negedge clk);
    chk("busy addr stable", data_addr_op, 32'h400);
    chk("busy we stable", {31'd0, data_we_op}, 32'd0);
    lsu_req_ip = 1'b0; alu_valid_ip = 1'b0; lsu_we_ip = 1'b0;
    grant(0);
    lsu_req_ip = 1'b1; alu_valid_ip = 1'b1; alu_result_ip = 32'h600;
    @(negedge clk);
    lsu_req_ip = 1'b0; alu_valid_ip = 1'b0;
    respond(32'hCAFEF00D);
    wait_done("busy");
    seen = 1'b0;
    repeat (4) begin
      if (data_req_op || lsu_busy_op) seen = 1'b1;
      @(negedge clk);
    end
    chk("dropped request not replayed", {31'd0, seen}, 32'd0);

    // Reset in WAIT_RVALID: outputs clear at once, no completion afterwards.
    issue(1'b1, 2'b10, 1'b0, 32'h700, 32'h1111_2222);
    expect_req("rst", 32'h700, 4'b1111, 1'b1, 32'h1111_2222);
    lsu_req_ip = 1'b1; alu_valid_ip = 1'b1; alu_result_ip = 32'h800;
    @(negedge clk);
    lsu_req_ip = 1'b0; alu_valid_ip = 1'b0;
    chk("rst second req ignored", data_addr_op, 32'h700);
    grant(0);
    chk("rst in WAIT_RVALID", {31'd0, lsu_busy_op && !data_req_op}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst flags", {27'd0, data_req_op, data_we_op, lsu_busy_op, lsu_valid_op, lsu_err_op}, 32'd0);
    chk("rst addr",  data_addr_op, 32'd0);
    chk("rst be",    {28'd0, data_be_op}, 32'd0);
    chk("rst wdata", data_wdata_op, 32'd0);
    chk("rst rdata", lsu_rdata_op, 32'd0);
    last_rdata = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    data_rvalid_ip = 1'b1;
    repeat (5) begin
      if (lsu_valid_op || lsu_err_op || data_req_op) seen = 1'b1;
      @(negedge clk);
    end
    data_rvalid_ip = 1'b0;
    chk("rst no completion", {31'd0, seen}, 32'd0);

    // Misaligned word load at 0x101.
`ifdef LSU_MISALIGN_CHECK_EN
    push_exp(1'b1, last_rdata);
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0);
    chk("misalign no req", {31'd0, data_req_op}, 32'd0);
    wait_done("misalign");
    chk("misalign still idle", {30'd0, data_req_op, lsu_busy_op}, 32'd0);
`else
    push_exp(1'b0, 32'h89AB_CDEF);
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0);
    expect_req("misalign", 32'h100, 4'b1111, 1'b0, 32'd0);
    grant(0);
    respond(32'h89AB_CDEF);
    wait_done("misalign");
`endif

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent waiting in WAIT_GNT or WAIT_RVALID before the access is aborted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 lsu_req_ip  input  1  decode requests a load/store this cycle.
REQ-005 lsu_we_ip  input  1  1 = store, 0 = load.
REQ-006 lsu_size_ip  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 lsu_unsigned_ip  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-008 alu_result_ip  input  32  effective byte address from ALU.
REQ-009 alu_valid_ip  input  1  ALU result valid.
REQ-010 lsu_wdata_ip  input  32  store data, LSB-aligned.
REQ-011 data_req_op / data_we_op  output  1 each  memory request and write-enable.
REQ-012 data_addr_op  output  32  word address, bits [1:0] = 0.
REQ-013 data_be_op  output  4  byte enables; data_wdata_op  output  32  lane-shifted store data.
REQ-014 data_gnt_ip / data_rvalid_ip  input  1 each  memory grant and response valid; data_rdata_ip  input  32  read word.
REQ-015 lsu_rdata_op  output  32  extended load result; lsu_valid_op  output  1  one-cycle completion pulse; lsu_busy_op  output  1  access in flight; lsu_err_op  output  1  one-cycle error pulse.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_GNT and WAIT_RVALID.
REQ-017 In IDLE, lsu_req_ip && alu_valid_ip SHALL register the address, byte enables, shifted wdata, size, sign and we, then move to WAIT_GNT on the next edge.
REQ-018 A request SHALL NOT be accepted while lsu_busy_op = 1 (any non-IDLE state); such a request SHALL be ignored.
REQ-019 data_req_op SHALL be 1 exactly in WAIT_GNT, with addr/we/be/wdata held stable until the grant is received.
REQ-020 On data_gnt_ip in WAIT_GNT, the FSM SHALL move to WAIT_RVALID; data_rvalid_ip SHALL be ignored outside WAIT_RVALID.
REQ-021 On data_rvalid_ip in WAIT_RVALID, the FSM SHALL return to IDLE and pulse lsu_valid_op for one cycle, registered; the access is therefore complete at least 3 cycles after acceptance.
REQ-022 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-023 Store data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-024 Load result: the selected lane(s) SHALL be right-aligned and sign- or zero-extended to 32 bits per the registered lsu_unsigned_ip; for stores, lsu_rdata_op SHALL be 0.
REQ-025 lsu_rdata_op SHALL hold its value until the next completion.
REQ-026 A wait counter SHALL reset to 0 on every state entry; reaching TIMEOUT_CYCLES in WAIT_GNT or WAIT_RVALID SHALL force IDLE, pulse lsu_err_op and leave lsu_rdata_op unchanged.

Reset
REQ-027 Asserting reset at any time, including mid-access, SHALL immediately force IDLE, clear the counter, and drive every output to 0.
REQ-028 An access interrupted by reset SHALL NOT produce lsu_valid_op or lsu_err_op.

Configuration
REQ-029 With macro LSU_MISALIGN_CHECK_EN defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL issue no memory request, pulse lsu_err_op one cycle after acceptance, and remain in IDLE.
REQ-030 Without LSU_MISALIGN_CHECK_EN, misaligned address bits SHALL be forced aligned (half: addr[0] = 0; word: addr[1:0] = 0) and the access SHALL proceed normally.

Verification
REQ-031 Word load at 0x100: gnt after 1 cycle, rvalid with rdata 0xDEADBEEF -> data_addr_op = 0x100, be = 1111, lsu_rdata_op = 0xDEADBEEF, single lsu_valid_op pulse.
REQ-032 Byte load at 0x103, signed, rdata 0x80FF_0000 -> be = 1000, lsu_rdata_op = 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-033 Half store 0x1234 at 0x202 -> data_addr_op = 0x200, be = 1100, data_wdata_op = 0x12341234, data_we_op = 1.
REQ-034 gnt withheld for 16 cycles (TIMEOUT_CYCLES = 16) -> lsu_err_op pulse, FSM returns to IDLE, no lsu_valid_op.
REQ-035 Second request while busy, then reset asserted in WAIT_RVALID -> second request ignored, all outputs 0 immediately, no completion pulse.
REQ-036 Word load at 0x101 -> with LSU_MISALIGN_CHECK_EN: no data_req_op and lsu_err_op pulse; without it: data_addr_op = 0x100 and normal completion.
